// File: rtl/vga_pkg.sv
// XGA 1024x768@60 timing constants and count type, shared by the timing generator and drawing modules.
// All values are in pixel clocks (horizontal) or lines (vertical).
package vga_pkg;

  typedef logic [10:0] vga_cnt_t;

  localparam vga_cnt_t H_ACTIVE = 11'd1024;
  localparam vga_cnt_t H_FP     = 11'd24;
  localparam vga_cnt_t H_SYNC   = 11'd136;
  localparam vga_cnt_t H_BP     = 11'd160;
  localparam vga_cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam vga_cnt_t V_ACTIVE = 11'd768;
  localparam vga_cnt_t V_FP     = 11'd3;
  localparam vga_cnt_t V_SYNC   = 11'd6;
  localparam vga_cnt_t V_BP     = 11'd29;
  localparam vga_cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Derived terminal counts and inclusive sync windows.
  localparam vga_cnt_t H_LAST       = H_TOTAL - 11'd1;
  localparam vga_cnt_t V_LAST       = V_TOTAL - 11'd1;
  localparam vga_cnt_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam vga_cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 11'd1;
  localparam vga_cnt_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam vga_cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 11'd1;

endpackage

// File: rtl/vga_init_if.sv
// Pixel position and active-high sync/blank flags handed from the timing generator to the drawing chain.
interface vga_init_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_timing.sv
// XGA raster generator: cascaded h/v counters with zero-skew registered flags, sof pulse and frame counter.
// One-cycle latency from en; en=0 freezes every output, stretching a pending sof.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_init_if.out     vga_out,
  output logic        sof,
  output logic [15:0] frame_cnt
);

  vga_cnt_t    hcount_q, vcount_q;
  vga_cnt_t    hcount_d, vcount_d;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic        hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic        sof_q;
  logic [15:0] frame_cnt_q;
  logic        h_wrap, v_wrap, frame_wrap;

  // Flags decode the next counter values so they land in the same register stage as the counts.
  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    v_wrap     = (vcount_q == V_LAST);
    frame_wrap = h_wrap && v_wrap;

    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      hcount_d = '0;
      vcount_d = v_wrap ? '0 : vcount_q + 11'd1;
    end

    hblnk_d = (hcount_d >= H_ACTIVE);
    hsync_d = (hcount_d >= H_SYNC_START) && (hcount_d <= H_SYNC_END);
    vblnk_d = (vcount_d >= V_ACTIVE);
    vsync_d = (vcount_d >= V_SYNC_START) && (vcount_d <= V_SYNC_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (en) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      sof_q    <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign sof            = sof_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: the driver queues expected raster state per cycle, a monitor compares.
module tb_vga_timing;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sof;
  logic [15:0] frame_cnt;

  vga_init_if vga_if ();

  vga_timing dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .vga_out   (vga_if),
    .sof       (sof),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        sof;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int    due;
    bit    late;
    obs_t  o;
    string nm;
  } exp_t;

  exp_t        q[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  int          h_m, v_m;
  logic        sof_m;
  logic [15:0] fc_m;

  logic [10:0] pre_h, pre_v;
  logic [15:0] pre_fc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(int h, int v, logic s, logic [15:0] fc);
    obs_t o;
    o.h   = 11'(h);
    o.v   = 11'(v);
    o.hb  = (h >= 1024);
    o.hs  = (h >= 1048) && (h <= 1183);
    o.vb  = (v >= 768);
    o.vs  = (v >= 771) && (v <= 776);
    o.sof = s;
    o.fc  = fc;
    return o;
  endfunction

  function automatic void push(int due, bit late, obs_t o, string nm);
    exp_t e;
    e.due  = due;
    e.late = late;
    e.o    = o;
    e.nm   = nm;
    q.push_back(e);
  endfunction

  // Monitor: samples 2 ns and 4 ns after each falling edge, well clear of the rising edge.
  task automatic drain(bit ph);
    exp_t e;
    obs_t act;
    while (q.size() > 0 && (q[0].due < cyc || (q[0].due == cyc && q[0].late <= ph))) begin
      e = q.pop_front();
      checks++;
      act = {vga_if.hcount, vga_if.vcount, vga_if.hsync, vga_if.vsync,
             vga_if.hblnk, vga_if.vblnk, sof, frame_cnt};
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: sample slot missed, at cycle %0d but due %0d", e.nm, cyc, e.due);
      end else if (act !== e.o) begin
        errors++;
        $display("FAIL %s cyc=%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%h, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%h",
                 e.nm, cyc, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.sof, act.fc,
                 e.o.h, e.o.v, e.o.hs, e.o.vs, e.o.hb, e.o.vb, e.o.sof, e.o.fc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      drain(1'b0);
      #2;
      drain(1'b1);
    end
  end

  // Driver steps: called at a falling edge (or just before the rising edge), return at the next falling edge.
  task automatic step_en(string nm);
    en = 1'b1;
    sof_m = 1'b0;
    if (h_m == 1343) begin
      h_m = 0;
      if (v_m == 805) begin
        v_m   = 0;
        sof_m = 1'b1;
        fc_m  = fc_m + 16'd1;
      end else begin
        v_m = v_m + 1;
      end
    end else begin
      h_m = h_m + 1;
    end
    push(cyc + 1, 1'b0, mk(h_m, v_m, sof_m, fc_m), nm);
    @(negedge clk);
  endtask

  task automatic step_hold(string nm);
    en = 1'b0;
    push(cyc + 1, 1'b0, mk(h_m, v_m, sof_m, fc_m), nm);
    @(negedge clk);
  endtask

  // Jumps the raster to a chosen position after this cycle's sample, before the next rising edge.
  task preload(input int h, input int v, input logic [15:0] fc);
    #3;
    pre_h  = 11'(h);
    pre_v  = 11'(v);
    pre_fc = fc;
    force dut.hcount_q    = pre_h;
    force dut.vcount_q    = pre_v;
    force dut.frame_cnt_q = pre_fc;
    force dut.sof_q       = 1'b0;
    #1;
    release dut.hcount_q;
    release dut.vcount_q;
    release dut.frame_cnt_q;
    release dut.sof_q;
    h_m   = h;
    v_m   = v;
    fc_m  = fc;
    sof_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit with %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    h_m = 0; v_m = 0; sof_m = 1'b0; fc_m = 16'd0;

    // Reset held for five cycles, outputs all zero throughout.
    repeat (5) begin
      @(negedge clk);
      push(cyc, 1'b0, '0, "reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    // First line plus wrap into line 1: hblnk at 1024, hsync 1048..1183, 1343 -> (0,1).
    for (int i = 0; i < 1346; i++) step_en("line0");

    // Eight lines across the vertical sync window.
    preload(1343, 769, 16'd0);
    for (int i = 0; i < 8 * 1344 + 1; i++) step_en("vsync_lines");

    // Frame wrap with a 10-cycle stall at (1343,805), then a stretched sof.
    preload(1340, 805, 16'd0);
    for (int i = 0; i < 3; i++) step_en("pre_wrap");
    for (int i = 0; i < 10; i++) step_hold("stall_last");
    step_en("frame_wrap");
    for (int i = 0; i < 3; i++) step_hold("sof_stretch");
    step_en("post_wrap");
    step_en("post_wrap2");

    // frame_cnt rolls over from FFFF to 0 on the wrap edge.
    preload(1342, 805, 16'hFFFF);
    step_en("fc_pre");
    step_en("fc_wrap");
    step_en("fc_post");

    // Asynchronous reset between edges, mid-frame.
    preload(499, 400, 16'd7);
    step_en("arst_pos");
    #3;
    rst = 1'b1;
    push(cyc, 1'b1, '0, "arst_async");
    @(negedge clk);
    push(cyc, 1'b0, '0, "arst_hold");
    @(negedge clk);
    rst = 1'b0;
    h_m = 0; v_m = 0; sof_m = 1'b0; fc_m = 16'd0;
    step_en("arst_first");
    step_en("arst_second");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
      checks = checks + q.size();
      errors = errors + q.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  input  1  pixel clock (65 MHz, XGA).
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; when 0, all counters and outputs hold their values.
REQ-005 vga_out  vga_init_if.out  --  carries hcount[10:0], vcount[10:0], hsync, vsync, hblnk and vblnk to the drawing chain.
REQ-006 sof  output  1  start-of-frame pulse; 1 for exactly one enabled cycle while vga_out shows position (0,0) after a frame wrap.
REQ-007 frame_cnt  output  16  count of completed frames.

Function
REQ-008 The timing SHALL be 1024x768 at 60 Hz, using vga_pkg constants:
- H: active 1024, front porch 24, sync 136, back porch 160, total 1344.
- V: active 768, front porch 3, sync 6, back porch 29, total 806.
REQ-009 hcount SHALL increment by 1 on each clk edge with en=1, and wrap 1343 -> 0.
REQ-010 vcount SHALL increment only on the edge where hcount wraps, and wrap 805 -> 0 on the edge where (hcount,vcount) = (1343,805).
REQ-011 All vga_out fields SHALL be registered, with no combinational path from inputs to outputs.
REQ-012 The flags SHALL be decoded from the next-state counter values, so that they correspond to the hcount/vcount presented in the same cycle (zero skew):
- hblnk = (hcount >= 1024)
- hsync = (1048 <= hcount <= 1183)
- vblnk = (vcount >= 768)
- vsync = (771 <= vcount <= 776)
REQ-013 Sync SHALL be active-high on the interface; pin polarity inversion is out of scope.
REQ-014 Counter arithmetic SHALL be 11-bit unsigned; terminal-count compares SHALL be equality (==), never overflow-based.
REQ-015 sof SHALL assert on the edge where outputs transition to (0,0) from (1343,805), and deassert on the next enabled edge.
REQ-016 While en=0, sof SHALL hold its current value; a sof pulse is therefore stretched, not lost.
REQ-017 frame_cnt SHALL increment on the same edge sof asserts, and wrap 16'hFFFF -> 0.
REQ-018 Latency from en assertion to the first counter change SHALL be 1 clk edge.
REQ-019 On the wrap edge, hcount, vcount and all flags SHALL update simultaneously; no intermediate value (e.g. hcount=0, vcount=805 after the frame wrap) may appear.

Reset
REQ-020 While rst=1, outputs SHALL take these values, asynchronously:
- hcount=0, vcount=0
- hsync=vsync=hblnk=vblnk=0
- sof=0, frame_cnt=0
REQ-021 The first enabled edge after reset release SHALL produce hcount=1 and vcount=0; reset itself SHALL NOT produce a sof pulse.
REQ-022 Reset asserted mid-line or mid-frame SHALL immediately return all outputs to the REQ-020 values; no partial-frame state is retained.

Structure
REQ-023 The H/V active, front-porch, sync, back-porch and total constants SHALL reside in vga_pkg, shared with the drawing modules.
REQ-024 The 11-bit count width SHALL be a vga_pkg typedef.
REQ-025 The block SHALL contain no sub-modules; the two cascaded counters, flag decode and frame logic SHALL be inline in one always_ff with an always_comb next-state section.
REQ-026 The vga_init_if definition SHALL be reused unchanged.

Verification
REQ-027 Reset/start: hold rst=1 for 5 clk, release with en=1 -> cycle 1 gives hcount=1, vcount=0 with all flags 0; sof stays 0 for the whole first frame until the wrap.
REQ-028 Line boundaries: run one line -> hblnk rises exactly when hcount=1024; hsync is 1 for hcount 1048..1183 (136 cycles); hcount=1343 is followed by hcount=0 with vcount=1.
REQ-029 Frame wrap: run 1344*806 cycles -> vsync is high for 6 lines (vcount 771..776); at (0,0) sof=1 for 1 cycle and frame_cnt=1.
REQ-030 Enable stall: drop en for 10 cycles at hcount=1343, vcount=805 -> outputs frozen; the first enabled edge gives (0,0), sof=1 and frame_cnt increments once only.
REQ-031 Async reset mid-frame: assert rst at hcount=500, vcount=400 between clock edges -> all outputs are 0 before the next clk edge.
REQ-032 frame_cnt wrap: force frame_cnt=16'hFFFF, complete one frame -> frame_cnt=0 and sof=1.
